// File: rtl/msg_ram_stream.sv
// rtl/msg_ram_stream.sv - message buffer with independent write port and burst read streamer
// Optional init image: define MSG_RAM_PRELOAD_EN.
module msg_ram_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int MSGLEN     = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH:0]   rd_len,
    output logic                  rd_busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   rem;
    logic [ADDR_WIDTH:0]   start_len;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

`ifdef MSG_RAM_PRELOAD_EN
    initial begin
        for (int k = 0; k < RAM_DEPTH; k++)
            mem[k] = (k < MSGLEN) ? DATA_WIDTH'(k) : '0;
    end
`endif

    // Memory is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign start_len = (rd_len > DEPTH_LEN) ? DEPTH_LEN : rd_len;

    // Reads sample mem before this edge's write lands, giving read-first collisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_busy   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            ptr       <= '0;
            rem       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start && rd_len != '0) begin
                        state     <= STREAM;
                        rd_busy   <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= mem[rd_addr];
                        out_last  <= (start_len == (ADDR_WIDTH+1)'(1));
                        rem       <= start_len;
                        ptr       <= next_addr(rd_addr);
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (rem > (ADDR_WIDTH+1)'(1)) begin
                            out_data <= mem[ptr];
                            out_last <= (rem == (ADDR_WIDTH+1)'(2));
                            ptr      <= next_addr(ptr);
                            rem      <= rem - 1'b1;
                        end else begin
                            state     <= IDLE;
                            rd_busy   <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
